// File: rtl/seq_tx_1011.sv
// Serial frame transmitter: sync pattern, MSB-first payload, zero gap.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_tx_1011 #(
    parameter int         DATA_W   = 8,
    parameter int         GAP_LEN  = 2,
    parameter logic [3:0] SYNC_PAT = 4'b1011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int MAX_DG = (DATA_W > GAP_LEN) ? DATA_W : GAP_LEN;
    localparam int MAX_L  = (MAX_DG > 4) ? MAX_DG : 4;
    localparam int CW     = $clog2(MAX_L + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] SYNC_END = CW'(4);
    localparam logic [CW-1:0] DATA_END = CW'(DATA_W);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PAR,
        GAP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        sync_sh;
`ifdef SEQ_TX_PARITY_EN
    logic              par_bit;
`endif

    assign tx_ready = reset && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sync_sh    <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (tx_valid) begin
                        // First sync bit leaves on the handshake edge itself
                        shreg     <= tx_data;
                        sync_sh   <= SYNC_PAT[2:0];
                        out_bit   <= SYNC_PAT[3];
                        out_valid <= 1'b1;
                        cnt       <= ONE;
                        state     <= SYNC;
`ifdef SEQ_TX_PARITY_EN
                        par_bit   <= ^tx_data;
`endif
                    end else begin
                        out_bit   <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                SYNC: begin
                    if (cnt == SYNC_END) begin
                        out_bit <= shreg[DATA_W-1];
                        shreg   <= shreg << 1;
                        cnt     <= ONE;
                        state   <= DATA;
                    end else begin
                        out_bit <= sync_sh[2];
                        sync_sh <= {sync_sh[1:0], 1'b0};
                        cnt     <= cnt + ONE;
                    end
                end
                DATA: begin
                    if (cnt == DATA_END) begin
`ifdef SEQ_TX_PARITY_EN
                        out_bit    <= par_bit;
                        state      <= PAR;
`else
                        out_bit    <= 1'b0;
                        cnt        <= ONE;
                        frame_done <= (GAP_LEN == 1);
                        state      <= GAP;
`endif
                    end else begin
                        out_bit <= shreg[DATA_W-1];
                        shreg   <= shreg << 1;
                        cnt     <= cnt + ONE;
                    end
                end
                PAR: begin
                    out_bit    <= 1'b0;
                    cnt        <= ONE;
                    frame_done <= (GAP_LEN == 1);
                    state      <= GAP;
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        out_bit    <= 1'b0;
                        out_valid  <= 1'b0;
                        frame_done <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt        <= cnt + ONE;
                        frame_done <= ((cnt + ONE) == GAP_END);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx_1011.sv
// Scoreboard bench for seq_tx_1011 with an inline 1011 detector on the line.
// Honours SEQ_TX_PARITY_EN the same way as the design.
module tb_seq_tx_1011;

    localparam int DATA_W  = 8;
    localparam int GAP_LEN = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int F = 4 + DATA_W + GAP_LEN + 1;
`else
    localparam int F = 4 + DATA_W + GAP_LEN;
`endif

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              out_bit;
    logic              out_valid;
    logic              frame_done;

    typedef struct packed {
        logic b;
        logic fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_count = 0;
    int   seen_count = 0;
    int   run_len = 0;
    logic [3:0] det_sh = '0;

    seq_tx_1011 #(
        .DATA_W  (DATA_W),
        .GAP_LEN (GAP_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_frame(input logic [DATA_W-1:0] w);
        logic [3:0] sp;
        exp_t e;
        sp = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            e.b = sp[i]; e.fd = 1'b0; q.push_back(e);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            e.b = w[i]; e.fd = 1'b0; q.push_back(e);
        end
`ifdef SEQ_TX_PARITY_EN
        e.b = ^w; e.fd = 1'b0; q.push_back(e);
`endif
        for (int i = 0; i < GAP_LEN; i++) begin
            e.b = 1'b0; e.fd = (i == GAP_LEN - 1); q.push_back(e);
        end
    endfunction

    // Output monitor: pops the scoreboard on every valid bit
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (frame_done === 1'b1) fd_count++;
            if (out_valid === 1'b1) begin
                exp_t e;
                run_len++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit got %b expected none", out_bit);
                end else begin
                    e = q.pop_front();
                    if (out_bit !== e.b || frame_done !== e.fd) begin
                        errors++;
                        $display("FAIL serial_bit got %b/%b expected %b/%b",
                                 out_bit, frame_done, e.b, e.fd);
                    end
                end
            end else begin
                if (run_len != 0) begin
                    checks++;
                    if (run_len != F) begin
                        errors++;
                        $display("FAIL frame_len got %0d expected %0d", run_len, F);
                    end
                end
                run_len = 0;
                checks++;
                if (out_bit !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_line got %b/%b expected 0/0", out_bit, frame_done);
                end
            end
            // Non-overlapping 1011 detector fed straight from the line
            if ({det_sh[2:0], out_bit} == 4'b1011) begin
                seen_count++;
                det_sh = '0;
            end else begin
                det_sh = {det_sh[2:0], out_bit};
            end
        end else begin
            run_len = 0;
            det_sh = '0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got %b expected 1", tx_ready);
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        wait_ready();
        tx_data  = w;
        tx_valid = 1'b1;
        push_frame(w);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = DATA_W'($urandom);
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency got v=%b b=%b r=%b expected 1 1 0",
                     out_valid, out_bit, tx_ready);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || out_valid !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (tx_ready !== 1'b0 || out_valid !== 1'b0 ||
                out_bit !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state got r=%b v=%b b=%b d=%b expected 0 0 0 0",
                         tx_ready, out_valid, out_bit, frame_done);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got r=%b v=%b expected 1 0", tx_ready, out_valid);
        end
    endtask

    task automatic test_frame(input logic [DATA_W-1:0] w);
        int fd0;
        fd0 = fd_count;
        send_word(w);
        wait_drain();
        checks++;
        if (fd_count != fd0 + 1) begin
            errors++;
            $display("FAIL frame_done_count got %0d expected %0d", fd_count - fd0, 1);
        end
    endtask

    task automatic test_back_to_back();
        int fd0;
        int n;
        fd0 = fd_count;
        wait_ready();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        push_frame(8'hFF);
        push_frame(8'h00);
        @(negedge clk);
        tx_data = 8'h00;
        n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1 || out_valid !== 1'b0 || fd_count != fd0 + 1) begin
            errors++;
            $display("FAIL b2b_idle got r=%b v=%b fd=%0d expected 1 0 1",
                     tx_ready, out_valid, fd_count - fd0);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got %b expected 1", out_valid);
        end
        wait_drain();
        repeat (4) @(negedge clk);
        checks++;
        if (fd_count != fd0 + 2) begin
            errors++;
            $display("FAIL b2b_frames got %0d expected 2", fd_count - fd0);
        end
    endtask

    task automatic test_reset_mid();
        int fd0;
        fd0 = fd_count;
        send_word(8'h5A);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b d=%b r=%b expected 0 0 0",
                     out_valid, frame_done, tx_ready);
        end
        q.delete();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (fd_count != fd0) begin
            errors++;
            $display("FAIL mid_reset_done got %0d expected 0", fd_count - fd0);
        end
        test_frame(8'h3C);
    endtask

    task automatic test_detector();
        int s0;
        s0 = seen_count;
        test_frame(8'hA5);
        checks++;
        if (seen_count != s0 + 1) begin
            errors++;
            $display("FAIL seq_seen got %0d expected 1", seen_count - s0);
        end
        s0 = seen_count;
        test_frame(8'hA5);
        checks++;
        if (seen_count != s0 + 1) begin
            errors++;
            $display("FAIL seq_seen_2 got %0d expected 1", seen_count - s0);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        test_frame(8'h01);
        test_frame(8'h80);
        test_back_to_back();
        test_reset_mid();
        test_detector();
        for (int i = 0; i < 4; i++) test_frame(DATA_W'($urandom));
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
